alu_seq: RTL
============

# alu_seq

Parametrised, multi-cycle successor to the single-cycle datapath ALU. Keeps the existing single-cycle operation set (ADD, SUB, OR, LUI) and adds RV32M-style multiply, divide and remainder, computed by an iterative radix-2 engine. A start/ready/done handshake lets the control unit stall the pipeline while an iterative operation runs. Sits in the execute stage beside the register file read ports.

## Interface
- `WIDTH`, default 32: operand and result width; must be ≥ 13 and even.
- `LUI_SHIFT`, default 12: left-shift amount applied by LUI.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start_i`  in  1  request; accepted only on an edge where `start_i` and `ready_o` are both 1.
- `ALU_Operation_i`  in  4  operation code, sampled at accept.
- `A_i`  in  WIDTH  operand A, sampled at accept.
- `B_i`  in  WIDTH  operand B, sampled at accept.
- `ready_o`  out  1  1 when idle and able to accept.
- `done_o`  out  1  one-cycle pulse: result valid.
- `ALU_Result_o`  out  WIDTH  registered result; holds until the next `done_o`.
- `Zero_o`  out  1  1 iff `ALU_Result_o` == 0; registered together with the result.

## Operation
- Op codes:
  - ADD 0000: A+B mod 2^WIDTH.
  - SUB 0001: A−B mod 2^WIDTH.
  - OR 0011.
  - LUI 0101: B<<LUI_SHIFT, truncated.
  - MUL 1000: low WIDTH bits of A×B.
  - MULHU 1001: high WIDTH bits of the unsigned product.
  - DIV 1100 and REM 1101: signed, quotient truncated toward zero; remainder takes the sign of the dividend.
  - DIVU 1110 and REMU 1111: unsigned.
  - Any other code: result 0, short-path.
- States:
  - IDLE (`ready_o`=1).
  - MUL: WIDTH iterations of shift-add over the 2·WIDTH product register.
  - DIV: WIDTH iterations of restoring shift-subtract on the magnitudes.
  - FIX: select product half, or apply sign correction to the quotient/remainder, then write the result.
  - Every path returns to IDLE.
- Short path (ADD/SUB/OR/LUI/undefined) is computed at accept and written directly; the state stays IDLE.
- Division special cases take the short path:
  - B=0: quotient all-ones, remainder = A.
  - Signed A=−2^(WIDTH−1) and B=−1: quotient = A, remainder = 0.
- `start_i` while not ready is ignored; it is neither queued nor flagged.
- Operands are captured internally at accept, so `A_i`/`B_i` may change afterwards.

## Timing
- Reset values: state IDLE, `ready_o`=1 from the first edge after reset, `done_o`=0, `ALU_Result_o`=0, `Zero_o`=1, iteration counter 0.
- Accept at edge k:
  - Short path: `done_o`=1 in cycle k+1.
  - Iterative path: `ready_o` drops in cycle k+1. Iterations run on edges k+1…k+WIDTH, FIX on edge k+WIDTH+1, and `done_o`=1 in cycle k+WIDTH+2 (latency WIDTH+2; 34 for WIDTH=32).
- `ready_o` is 1 during the `done_o` cycle, so back-to-back accepts are allowed. A new short-path accept in the `done_o` cycle yields `done_o` on consecutive cycles.
- `reset` asserted mid-operation aborts it: no `done_o`, all values return to reset state on that edge.
- `reset` and `start_i` asserted together: reset wins and the request is dropped.
- The iteration counter is $clog2(WIDTH)+1 bits wide and terminates at exactly WIDTH.

## Structure
- Package `alu_pkg` holds:
  - the op-code localparams, with the existing four unchanged;
  - the state enum;
  - a helper function `is_iter(op)`.
- Sub-module `alu_iter_core` holds the shared shift-add/shift-subtract datapath, counter and FIX logic.
- Top level `alu_seq` holds the short-path logic, special-case detection, handshake and output registers.

## Test plan
1. ADD 7+(−7) → `done_o` 1 cycle after accept, result 0, `Zero_o`=1. LUI B=0x12345 → 0x12345000.
2. MUL 0xFFFFFFFF×0xFFFFFFFF → 0x00000001. MULHU on the same operands → 0xFFFFFFFE. `done_o` exactly 34 cycles after accept, `ready_o`=0 in between.
3. DIV −7/2 → 0xFFFFFFFD, REM → 0xFFFFFFFF. DIVU 100/7 → 14, REMU → 2.
4. DIVU 5/0 → 0xFFFFFFFF, REMU → 5. DIV 0x80000000/−1 → 0x80000000, REM → 0. All with latency 1.
5. `start_i` held high during a DIV → only one `done_o`, with the DIV result. SUB accepted in the `done_o` cycle → second `done_o` on the next cycle.
6. `reset` asserted at iteration 10 of a MUL → no `done_o`, result 0, `Zero_o`=1, `ready_o`=1. Repeat scenario 2 with WIDTH=16 → latency 18.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared op codes, FSM state encoding and op-class helpers for the sequential ALU.
package alu_pkg;

  // The first four codes are kept from the single-cycle datapath ALU.
  localparam logic [3:0] OpAdd   = 4'b0000;
  localparam logic [3:0] OpSub   = 4'b0001;
  localparam logic [3:0] OpOr    = 4'b0011;
  localparam logic [3:0] OpLui   = 4'b0101;
  localparam logic [3:0] OpMul   = 4'b1000;
  localparam logic [3:0] OpMulhu = 4'b1001;
  localparam logic [3:0] OpDiv   = 4'b1100;
  localparam logic [3:0] OpRem   = 4'b1101;
  localparam logic [3:0] OpDivu  = 4'b1110;
  localparam logic [3:0] OpRemu  = 4'b1111;

  typedef logic [1:0] state_t;
  localparam state_t StIdle = 2'd0;
  localparam state_t StMul  = 2'd1;
  localparam state_t StDiv  = 2'd2;
  localparam state_t StFix  = 2'd3;

  function automatic logic is_div(logic [3:0] op);
    return op[3:2] == 2'b11;
  endfunction

  function automatic logic is_iter(logic [3:0] op);
    return (op == OpMul) || (op == OpMulhu) || is_div(op);
  endfunction

endpackage

// File: rtl/alu_iter_core.sv
// Iterative radix-2 multiply / restoring-divide engine with a final fix-up cycle.
module alu_iter_core #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             idle_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] result_o
);
  import alu_pkg::*;

  localparam int unsigned     CntW    = $clog2(WIDTH) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [3:0]         op_q, op_d;
  logic               q_neg_q, q_neg_d, r_neg_q, r_neg_d;

  logic               signed_op, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag, acc_lo, acc_hi;
  logic [WIDTH:0]     add_sum, shifted, sub_diff;
  logic [2*WIDTH-1:0] mul_next, div_next;

  assign signed_op = (op_i == OpDiv) || (op_i == OpRem);
  assign a_neg     = signed_op & a_i[WIDTH-1];
  assign b_neg     = signed_op & b_i[WIDTH-1];
  assign a_mag     = a_neg ? (~a_i + 1'b1) : a_i;
  assign b_mag     = b_neg ? (~b_i + 1'b1) : b_i;

  assign acc_lo = acc_q[WIDTH-1:0];
  assign acc_hi = acc_q[2*WIDTH-1:WIDTH];

  // Multiply: {partial product, remaining multiplier bits}, shifted right each step.
  assign add_sum  = {1'b0, acc_hi} + (acc_q[0] ? {1'b0, opb_q} : '0);
  assign mul_next = {add_sum, acc_q[WIDTH-1:1]};

  // Divide: {remainder, dividend/quotient}, shifted left; quotient bits enter at the bottom.
  assign shifted  = acc_q[2*WIDTH-1:WIDTH-1];
  assign sub_diff = shifted - {1'b0, opb_q};
  assign div_next = sub_diff[WIDTH] ? {shifted[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                    : {sub_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

  always_comb begin
    case (op_q)
      OpMul:         result_o = acc_lo;
      OpMulhu:       result_o = acc_hi;
      OpDiv, OpDivu: result_o = q_neg_q ? (~acc_lo + 1'b1) : acc_lo;
      default:       result_o = r_neg_q ? (~acc_hi + 1'b1) : acc_hi;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opb_d   = opb_q;
    op_d    = op_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    valid_o = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          op_d  = op_i;
          cnt_d = '0;
          if (is_div(op_i)) begin
            state_d = StDiv;
            acc_d   = {{WIDTH{1'b0}}, a_mag};
            opb_d   = b_mag;
            q_neg_d = a_neg ^ b_neg;
            r_neg_d = a_neg;
          end else begin
            state_d = StMul;
            acc_d   = {{WIDTH{1'b0}}, a_i};
            opb_d   = b_i;
            q_neg_d = 1'b0;
            r_neg_d = 1'b0;
          end
        end
      end
      StMul, StDiv: begin
        acc_d = (state_q == StMul) ? mul_next : div_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntLast) state_d = StFix;
      end
      StFix: begin
        valid_o = 1'b1;
        cnt_d   = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      acc_q   <= '0;
      opb_q   <= '0;
      op_q    <= OpAdd;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opb_q   <= opb_d;
      op_q    <= op_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
    end
  end

  assign idle_o = (state_q == StIdle);

endmodule

// File: rtl/alu_seq.sv
// Execute-stage ALU: single-cycle ops and division corner cases resolve at accept,
// multiply/divide are handed to the iterative core behind a start/ready/done handshake.
module alu_seq #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned LUI_SHIFT = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [3:0]       ALU_Operation_i,
  input  logic [WIDTH-1:0] A_i,
  input  logic [WIDTH-1:0] B_i,
  output logic             ready_o,
  output logic             done_o,
  output logic [WIDTH-1:0] ALU_Result_o,
  output logic             Zero_o
);
  import alu_pkg::*;

  localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH-1){1'b0}}};

  logic             accept, b_zero, div_ovf, short_path;
  logic             core_idle, core_valid;
  logic [WIDTH-1:0] core_result, short_result;
  logic [WIDTH-1:0] result_q;
  logic             zero_q, done_q;

  assign accept  = start_i & ready_o;
  assign b_zero  = (B_i == '0);
  assign div_ovf = ((ALU_Operation_i == OpDiv) || (ALU_Operation_i == OpRem)) &&
                   (A_i == MinNeg) && (B_i == '1);
  // Divide by zero and signed overflow have closed-form answers, so skip the engine.
  assign short_path = !is_iter(ALU_Operation_i) ||
                      (is_div(ALU_Operation_i) && (b_zero || div_ovf));

  always_comb begin
    case (ALU_Operation_i)
      OpAdd:         short_result = A_i + B_i;
      OpSub:         short_result = A_i - B_i;
      OpOr:          short_result = A_i | B_i;
      OpLui:         short_result = B_i << LUI_SHIFT;
      OpDiv, OpDivu: short_result = b_zero ? '1 : A_i;
      OpRem, OpRemu: short_result = b_zero ? A_i : '0;
      default:       short_result = '0;
    endcase
  end

  alu_iter_core #(
    .WIDTH (WIDTH)
  ) u_iter_core (
    .clk      (clk),
    .reset    (reset),
    .start_i  (accept & ~short_path),
    .op_i     (ALU_Operation_i),
    .a_i      (A_i),
    .b_i      (B_i),
    .idle_o   (core_idle),
    .valid_o  (core_valid),
    .result_o (core_result)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      result_q <= '0;
      zero_q   <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept && short_path) begin
        result_q <= short_result;
        zero_q   <= (short_result == '0);
        done_q   <= 1'b1;
      end else if (core_valid) begin
        result_q <= core_result;
        zero_q   <= (core_result == '0);
        done_q   <= 1'b1;
      end
    end
  end

  assign ready_o      = core_idle;
  assign done_o       = done_q;
  assign ALU_Result_o = result_q;
  assign Zero_o       = zero_q;

endmodule
